// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and helpers for memory_bus_arbiter.
// Struct field widths follow the package defaults, which the top uses as its parameter defaults.
package memory_bus_arbiter_pkg;

  localparam int unsigned STATS_WIDTH    = 16;
  localparam int unsigned PKG_ID_WIDTH   = 8;
  localparam int unsigned PKG_ADDR_WIDTH = 32;
  localparam int unsigned PKG_DATA_WIDTH = 24;

  typedef struct packed {
    logic [PKG_ID_WIDTH-1:0]   id;
    logic [PKG_ADDR_WIDTH-1:0] address;
    logic [PKG_DATA_WIDTH-1:0] data;
    logic                      write;
  } mem_req_t;

  typedef struct packed {
    logic [PKG_ID_WIDTH-1:0]   id;
    logic [PKG_DATA_WIDTH-1:0] data;
  } mem_rsp_t;

  function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
    return (v == {STATS_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at NUM_MASTERS.
module rr_priority_pick #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IdxWidth    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IdxWidth-1:0]    ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IdxWidth-1:0]    grant_idx,
  output logic                   any
);

  always_comb begin
    int unsigned cand;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = (32'(ptr) + k) % NUM_MASTERS;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IdxWidth'(cand);
      end
    end
    any = found;
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin request arbiter and ID-routed response demux for one shared memory slave port.
// Optional counters (grantCount, stallCycles) enabled by MEMORY_BUS_ARBITER_STATS_EN.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned DATA_WIDTH      = PKG_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH   = PKG_ADDR_WIDTH,
  parameter int unsigned MASTER_ID_WIDTH = PKG_ID_WIDTH,
  parameter logic [MASTER_ID_WIDTH-1:0] MASTER_ID_BASE = 8'd4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] umsID,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]   umsAddress,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      umsData,
  input  logic [NUM_MASTERS-1:0]                 umsWrite,
  input  logic [NUM_MASTERS-1:0]                 umsValid,
  output logic [NUM_MASTERS-1:0]                 umsTaken,
  output logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] usmID,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]      usmData,
  output logic [NUM_MASTERS-1:0]                 usmValid,
  input  logic [NUM_MASTERS-1:0]                 usmTaken,
  output logic [MASTER_ID_WIDTH-1:0]             msID,
  output logic [ADDRESS_WIDTH-1:0]               msAddress,
  output logic [DATA_WIDTH-1:0]                  msData,
  output logic                                   msWrite,
  output logic                                   msValid,
  input  logic                                   msTaken,
  input  logic [MASTER_ID_WIDTH-1:0]             smID,
  input  logic [DATA_WIDTH-1:0]                  smData,
  input  logic                                   smValid,
  output logic                                   smTaken,
  output logic                                   routeError
`ifdef MEMORY_BUS_ARBITER_STATS_EN
  ,
  output logic [NUM_MASTERS*STATS_WIDTH-1:0]     grantCount,
  output logic [STATS_WIDTH-1:0]                 stallCycles
`endif
);

  localparam int unsigned IdxWidth = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // Request channel
  mem_req_t                ms_q;
  mem_req_t                req_sel;
  logic                    ms_valid_q;
  logic [IdxWidth-1:0]     ptr_q;
  logic [NUM_MASTERS-1:0]  grant;
  logic [IdxWidth-1:0]     grant_idx;
  logic                    grant_any;
  logic                    slot_free;

  rr_priority_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IdxWidth   (IdxWidth)
  ) u_pick (
    .req      (umsValid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (grant_any)
  );

  assign slot_free = !ms_valid_q || msTaken;
  assign umsTaken  = (!reset && slot_free) ? grant : '0;

  always_comb begin
    req_sel         = '0;
    req_sel.id      = umsID[grant_idx*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
    req_sel.address = umsAddress[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    req_sel.data    = umsData[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    req_sel.write   = umsWrite[grant_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ms_q       <= '0;
      ms_valid_q <= 1'b0;
      ptr_q      <= '0;
    end else if (slot_free) begin
      ms_valid_q <= grant_any;
      if (grant_any) begin
        ms_q  <= req_sel;
        ptr_q <= (grant_idx == IdxWidth'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign msID      = ms_q.id;
  assign msAddress = ms_q.address;
  assign msData    = ms_q.data;
  assign msWrite   = ms_q.write;
  assign msValid   = ms_valid_q;

  // Response channel
  mem_rsp_t                   usm_q [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]     usm_valid_q;
  logic [NUM_MASTERS-1:0]     usm_free;
  logic [MASTER_ID_WIDTH-1:0] rsp_off;
  logic [IdxWidth-1:0]        rsp_idx;
  logic                       rsp_in_range;
  logic                       rsp_accept;
  logic                       route_err_q;

  assign usm_free     = ~usm_valid_q | usmTaken;
  assign rsp_off      = smID - MASTER_ID_BASE;
  assign rsp_in_range = (smID >= MASTER_ID_BASE) && (32'(rsp_off) < NUM_MASTERS);
  assign rsp_idx      = IdxWidth'(rsp_off);
  assign rsp_accept   = smValid && rsp_in_range && usm_free[rsp_idx];
  // Unowned IDs are always taken so a bad beat can never wedge the downstream port.
  assign smTaken      = !reset && smValid && (!rsp_in_range || usm_free[rsp_idx]);

  always_ff @(posedge clock) begin
    if (reset) begin
      usm_valid_q <= '0;
      route_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        usm_q[i] <= '0;
      end
    end else begin
      if (smValid && !rsp_in_range) begin
        route_err_q <= 1'b1;
      end
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (rsp_accept && (rsp_idx == IdxWidth'(i))) begin
          usm_valid_q[i]  <= 1'b1;
          usm_q[i].id     <= smID;
          usm_q[i].data   <= smData;
        end else if (usmTaken[i]) begin
          usm_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_usm_out
    assign usmID[g*MASTER_ID_WIDTH +: MASTER_ID_WIDTH] = usm_q[g].id;
    assign usmData[g*DATA_WIDTH +: DATA_WIDTH]         = usm_q[g].data;
  end

  assign usmValid   = usm_valid_q;
  assign routeError = route_err_q;

`ifdef MEMORY_BUS_ARBITER_STATS_EN
  logic [STATS_WIDTH-1:0] grant_cnt_q [NUM_MASTERS];
  logic [STATS_WIDTH-1:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      if (ms_valid_q && !msTaken) begin
        stall_q <= sat_inc(stall_q);
      end
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (umsTaken[i]) begin
          grant_cnt_q[i] <= sat_inc(grant_cnt_q[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_stat_out
    assign grantCount[g*STATS_WIDTH +: STATS_WIDTH] = grant_cnt_q[g];
  end
  assign stallCycles = stall_q;
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed self-checking bench for memory_bus_arbiter (4 ports, ID base 4).
module tb_memory_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 24;
  localparam int AW = 32;
  localparam int IW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N*IW-1:0] umsID;
  logic [N*AW-1:0] umsAddress;
  logic [N*DW-1:0] umsData;
  logic [N-1:0]    umsWrite;
  logic [N-1:0]    umsValid;
  logic [N-1:0]    umsTaken;
  logic [N*IW-1:0] usmID;
  logic [N*DW-1:0] usmData;
  logic [N-1:0]    usmValid;
  logic [N-1:0]    usmTaken;
  logic [IW-1:0]   msID;
  logic [AW-1:0]   msAddress;
  logic [DW-1:0]   msData;
  logic            msWrite;
  logic            msValid;
  logic            msTaken;
  logic [IW-1:0]   smID;
  logic [DW-1:0]   smData;
  logic            smValid;
  logic            smTaken;
  logic            routeError;
`ifdef MEMORY_BUS_ARBITER_STATS_EN
  logic [N*16-1:0] grantCount;
  logic [15:0]     stallCycles;
`endif

  memory_bus_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .umsID     (umsID),
    .umsAddress(umsAddress),
    .umsData   (umsData),
    .umsWrite  (umsWrite),
    .umsValid  (umsValid),
    .umsTaken  (umsTaken),
    .usmID     (usmID),
    .usmData   (usmData),
    .usmValid  (usmValid),
    .usmTaken  (usmTaken),
    .msID      (msID),
    .msAddress (msAddress),
    .msData    (msData),
    .msWrite   (msWrite),
    .msValid   (msValid),
    .msTaken   (msTaken),
    .smID      (smID),
    .smData    (smData),
    .smValid   (smValid),
    .smTaken   (smTaken),
    .routeError(routeError)
`ifdef MEMORY_BUS_ARBITER_STATS_EN
    ,
    .grantCount (grantCount),
    .stallCycles(stallCycles)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int gcount[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int p, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic wr);
    umsID[p*IW +: IW]      = id;
    umsAddress[p*AW +: AW] = addr;
    umsData[p*DW +: DW]    = data;
    umsWrite[p]            = wr;
    umsValid[p]            = 1'b1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    umsID      = '0;
    umsAddress = '0;
    umsData    = '0;
    umsWrite   = '0;
    umsValid   = '0;
    usmTaken   = '0;
    msTaken    = 1'b0;
    smID       = '0;
    smData     = '0;
    smValid    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_msValid", msValid, 0);
    check("rst_msID", msID, 0);
    check("rst_usmValid", usmValid, 0);
    check("rst_umsTaken", umsTaken, 0);
    check("rst_smTaken", smTaken, 0);
    check("rst_routeError", routeError, 0);

    // Single master on port 2
    set_req(2, 8'd6, 32'h100, 24'hABCDEF, 1'b1);
    msTaken = 1'b1;
    #1 check("single_taken", umsTaken, 4'b0100);
    tick();
    umsValid = '0;
    #1;
    check("single_taken_drop", umsTaken, 0);
    check("single_msValid", msValid, 1);
    check("single_msID", msID, 8'd6);
    check("single_msAddress", msAddress, 32'h100);
    check("single_msData", msData, 24'hABCDEF);
    check("single_msWrite", msWrite, 1);
    tick();
    check("single_msValid_fall", msValid, 0);

    // Fairness: all ports requesting from pointer 0
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, IW'(4 + i), AW'(i * 16), DW'(i), 1'b0);
      gcount[i] = 0;
    end
    msTaken = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1 check("fair_grant", umsTaken, 64'(1 << (c % 4)));
      for (int i = 0; i < N; i++) gcount[i] += int'(umsTaken[i]);
      tick();
      check("fair_msID", msID, 64'(4 + (c % 4)));
    end
    for (int i = 0; i < N; i++) check("fair_count", gcount[i], 2);
    umsValid = '0;
    tick();
    check("fair_drain", msValid, 0);

    // Backpressure with ports 0 and 1 pending
    set_req(0, 8'd4, 32'h10, 24'h000111, 1'b1);
    set_req(1, 8'd5, 32'h20, 24'h000222, 1'b0);
    msTaken = 1'b0;
    #1 check("bp_first_grant", umsTaken, 4'b0001);
    tick();
    umsValid[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_no_taken", umsTaken, 0);
      check("bp_hold_valid", msValid, 1);
      check("bp_hold_addr", msAddress, 32'h10);
      tick();
    end
    msTaken = 1'b1;
    #1 check("bp_release_grant", umsTaken, 4'b0010);
    tick();
    umsValid = '0;
    #1;
    check("bp_second_id", msID, 8'd5);
    check("bp_second_addr", msAddress, 32'h20);
    tick();
    check("bp_idle", msValid, 0);

    // Response routing and per-port backpressure
    smValid = 1'b1;
    smID    = 8'd7;
    smData  = 24'h123456;
    #1 check("rsp_taken", smTaken, 1);
    tick();
    check("rsp_usmValid", usmValid, 4'b1000);
    check("rsp_usmData3", usmData[3*DW +: DW], 24'h123456);
    check("rsp_usmID3", usmID[3*IW +: IW], 8'd7);
    smData = 24'h654321;
    #1 check("rsp_bp", smTaken, 0);
    tick();
    check("rsp_bp_hold", usmData[3*DW +: DW], 24'h123456);
    check("rsp_bp_still", smTaken, 0);
    usmTaken = 4'b1000;
    #1 check("rsp_drain_taken", smTaken, 1);
    tick();
    smValid  = 1'b0;
    usmTaken = '0;
    #1;
    check("rsp_reload_valid", usmValid, 4'b1000);
    check("rsp_reload_data", usmData[3*DW +: DW], 24'h654321);
    usmTaken = 4'b1000;
    tick();
    usmTaken = '0;
    check("rsp_empty", usmValid, 0);

    // Bad IDs: below base and just past the last port
    smValid = 1'b1;
    smID    = 8'd2;
    #1 check("bad_taken", smTaken, 1);
    tick();
    smValid = 1'b0;
    check("bad_no_usm", usmValid, 0);
    check("bad_err", routeError, 1);
    tick();
    tick();
    check("bad_sticky", routeError, 1);
    do_reset();
    check("bad_reset", routeError, 0);
    smValid = 1'b1;
    smID    = 8'd8;
    #1 check("bad_hi_taken", smTaken, 1);
    tick();
    check("bad_hi_err", routeError, 1);
    check("bad_hi_no_usm", usmValid, 0);
    smID   = 8'd4;
    smData = 24'h0000AA;
    tick();
    smValid = 1'b0;
    check("rsp_port0", usmValid, 4'b0001);
    check("rsp_port0_data", usmData[0 +: DW], 24'h0000AA);

`ifdef MEMORY_BUS_ARBITER_STATS_EN
    do_reset();
    check("stat_rst_grant", grantCount[16 +: 16], 0);
    set_req(1, 8'd5, 32'h40, 24'h1, 1'b1);
    msTaken = 1'b1;
    tick();
    tick();
    tick();
    umsValid = '0;
    msTaken  = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("stat_grant1", grantCount[16 +: 16], 3);
    check("stat_stall", stallCycles, 4);
    set_req(1, 8'd5, 32'h40, 24'h1, 1'b1);
    msTaken = 1'b1;
    for (int c = 0; c < 70000; c++) tick();
    umsValid = '0;
    check("stat_sat", grantCount[16 +: 16], 16'hFFFF);
    check("stat_grant0", grantCount[0 +: 16], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
